vga_text_scan: RTL and testbench



---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_sync_counter.sv | 41 ++++
 rtl/vga_text_scan.sv | 78 +++++++
 tb/tb_vga_text_scan.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, text grid size and the scan pipeline stage type.
package vga_pkg;
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int TXT_COLS  = 80;
  localparam int TXT_ROWS  = 30;
  localparam int CNT_W     = 10;
  localparam int ADDR_W    = 12;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vis;
    logic [2:0] col;
    logic [3:0] row;
    logic       first;
  } pix_t;

  localparam pix_t PIX_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, col: 3'd0, row: 4'd0, first: 1'b0};
endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: horizontal/vertical raster counters advancing one pixel per pix_ce.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int H_TOTAL_P = H_TOTAL,
  parameter int V_TOTAL_P = V_TOTAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_ce_i,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o
);
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             h_wrap, v_wrap;

  assign h_wrap = h_q == CNT_W'(H_TOTAL_P - 1);
  assign v_wrap = v_q == CNT_W'(V_TOTAL_P - 1);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_ce_i) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) v_d = v_wrap ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt_o = h_q;
  assign v_cnt_o = v_q;
endmodule

// File: rtl/vga_text_scan.sv
// vga_text_scan: raster scan for an 80x30 text screen of 8x16 cells; sync/von/col/row are
// delayed two pixels so they line up with the character read back from the synchronous text RAM.
module vga_text_scan #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pix_ce,
  output logic [vga_pkg::ADDR_W-1:0] txt_addr,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       von,
  output logic [2:0]                 col,
  output logic [3:0]                 row,
  output logic                       frame_start
);
  import vga_pkg::pix_t, vga_pkg::PIX_IDLE, vga_pkg::CNT_W, vga_pkg::ADDR_W;

  localparam int HT     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_BEG = H_VISIBLE + H_FRONT;
  localparam int VS_BEG = V_VISIBLE + V_FRONT;

  logic [CNT_W-1:0]  h_cnt, v_cnt;
  logic [ADDR_W-1:0] addr_d, addr_q;
  pix_t              s0, s1_q, s2_q;
  logic              fs_q;

  vga_sync_counter #(.H_TOTAL_P(HT), .V_TOTAL_P(VT)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_ce_i (pix_ce),
    .h_cnt_o  (h_cnt),
    .v_cnt_o  (v_cnt)
  );

  always_comb begin
    s0.vis   = (h_cnt < CNT_W'(H_VISIBLE)) && (v_cnt < CNT_W'(V_VISIBLE));
    s0.hs    = !(h_cnt >= CNT_W'(HS_BEG) && h_cnt <= CNT_W'(HS_BEG + H_SYNC - 1));
    s0.vs    = !(v_cnt >= CNT_W'(VS_BEG) && v_cnt <= CNT_W'(VS_BEG + V_SYNC - 1));
    s0.col   = h_cnt[2:0];
    s0.row   = v_cnt[3:0];
    s0.first = (h_cnt == '0) && (v_cnt == '0);
    // char_row*80 as *64 + *16
    addr_d   = s0.vis ? (ADDR_W'(v_cnt[8:4]) << 6) + (ADDR_W'(v_cnt[8:4]) << 4) + ADDR_W'(h_cnt[9:3]) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= PIX_IDLE;
      s2_q   <= PIX_IDLE;
      addr_q <= '0;
      fs_q   <= 1'b0;
    end else begin
      fs_q <= pix_ce && s1_q.first;
      if (pix_ce) begin
        s1_q   <= s0;
        s2_q   <= s1_q;
        addr_q <= addr_d;
      end
    end
  end

  assign txt_addr    = addr_q;
  assign hsync       = s2_q.hs;
  assign vsync       = s2_q.vs;
  assign von         = s2_q.vis;
  assign col         = s2_q.col;
  assign row         = s2_q.row;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_text_scan.sv
// tb_vga_text_scan: directed checks of the text scan generator; vertical timing is shortened
// (16 visible lines, 21 total) so whole frames fit in a short run, horizontal timing is the default.
module tb_vga_text_scan;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_ce = 1'b0;
  logic [11:0] txt_addr;
  logic        hsync, vsync, von, frame_start;
  logic [2:0]  col;
  logic [3:0]  row;
  logic [22:0] out_v;
  int          checks = 0;
  int          errors = 0;
  int          k = 0;

  localparam logic [22:0] RST_V = {12'd0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};

  vga_text_scan #(.V_VISIBLE(16), .V_FRONT(2), .V_SYNC(2), .V_BACK(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_ce      (pix_ce),
    .txt_addr    (txt_addr),
    .hsync       (hsync),
    .vsync       (vsync),
    .von         (von),
    .col         (col),
    .row         (row),
    .frame_start (frame_start)
  );

  assign out_v = {txt_addr, hsync, vsync, von, col, row, frame_start};

  always #5 clk = ~clk;

  task automatic tick(input logic ce);
    pix_ce = ce;
    @(posedge clk);
    #1;
    if (ce) k++;
  endtask

  task automatic advance_to(input int t);
    while (k < t) tick(1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pix_ce = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick(1'b1);
    checks++;
    if (out_v !== RST_V) begin errors++; $display("FAIL reset_values: got %h want %h", out_v, RST_V); end
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic test_first();
    tick(1'b1);
    checks++;
    if ({txt_addr, von, frame_start} !== {12'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL first_ce1: addr/von/fs got %h want %h", {txt_addr, von, frame_start}, {12'd0, 2'b00});
    end
    tick(1'b1);
    checks++;
    if ({hsync, vsync, von, col, row, frame_start} !== {3'b111, 3'd0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL first_ce2: got %h want %h", {hsync, vsync, von, col, row, frame_start}, {3'b111, 3'd0, 4'd0, 1'b1});
    end
    tick(1'b1);
    checks++;
    if ({frame_start, col} !== {1'b0, 3'd1}) begin errors++; $display("FAIL first_ce3: fs/col got %h want %h", {frame_start, col}, 4'h1); end
    advance_to(9);
    checks++;
    if (txt_addr !== 12'd1) begin errors++; $display("FAIL addr_cell1: got %0d want 1", txt_addr); end
    tick(1'b1);
    checks++;
    if (col !== 3'd0) begin errors++; $display("FAIL col_wrap8: got %0d want 0", col); end
  endtask

  task automatic test_mid_reset();
    advance_to(8300);
    checks++;
    if ({txt_addr, von, col, row} !== {12'd37, 1'b1, 3'd2, 4'd10}) begin
      errors++; $display("FAIL pre_reset_pos: got %h want %h", {txt_addr, von, col, row}, {12'd37, 1'b1, 3'd2, 4'd10});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_v !== RST_V) begin errors++; $display("FAIL async_reset: got %h want %h", out_v, RST_V); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    tick(1'b1);
    checks++;
    if (frame_start !== 1'b0) begin errors++; $display("FAIL restart_ce1_fs: got %b want 0", frame_start); end
    tick(1'b1);
    checks++;
    if ({frame_start, von} !== 2'b11) begin errors++; $display("FAIL restart_ce2_fs: fs/von got %b want 11", {frame_start, von}); end
  endtask

  task automatic test_blank();
    advance_to(4640);
    checks++;
    if (txt_addr !== 12'd79) begin errors++; $display("FAIL addr_639_5: got %0d want 79", txt_addr); end
    tick(1'b1);
    checks++;
    if ({von, col, row} !== {1'b1, 3'd7, 4'd5}) begin errors++; $display("FAIL pix_639_5: got %h want %h", {von, col, row}, {1'b1, 3'd7, 4'd5}); end
    tick(1'b1);
    checks++;
    if (von !== 1'b0) begin errors++; $display("FAIL von_h640: got %b want 0", von); end
    advance_to(4657);
    checks++;
    if (hsync !== 1'b1) begin errors++; $display("FAIL hsync_h655: got %b want 1", hsync); end
    tick(1'b1);
    checks++;
    if (hsync !== 1'b0) begin errors++; $display("FAIL hsync_h656: got %b want 0", hsync); end
    advance_to(4659);
    checks++;
    if (txt_addr !== 12'd0) begin errors++; $display("FAIL addr_blank_658: got %0d want 0", txt_addr); end
    tick(1'b1);
    checks++;
    if ({hsync, von, col, row} !== {1'b0, 1'b0, 3'd2, 4'd5}) begin
      errors++; $display("FAIL pix_658_5: got %h want %h", {hsync, von, col, row}, {1'b0, 1'b0, 3'd2, 4'd5});
    end
    advance_to(4753);
    checks++;
    if (hsync !== 1'b0) begin errors++; $display("FAIL hsync_h751: got %b want 0", hsync); end
    tick(1'b1);
    checks++;
    if (hsync !== 1'b1) begin errors++; $display("FAIL hsync_h752: got %b want 1", hsync); end
  endtask

  task automatic test_last();
    advance_to(12640);
    checks++;
    if (txt_addr !== 12'd79) begin errors++; $display("FAIL addr_last_vis: got %0d want 79", txt_addr); end
    tick(1'b1);
    checks++;
    if ({von, col, row} !== {1'b1, 3'd7, 4'd15}) begin errors++; $display("FAIL pix_last_vis: got %h want %h", {von, col, row}, {1'b1, 3'd7, 4'd15}); end
    tick(1'b1);
    checks++;
    if (von !== 1'b0) begin errors++; $display("FAIL von_after_last: got %b want 0", von); end
    advance_to(12801);
    checks++;
    if (txt_addr !== 12'd0) begin errors++; $display("FAIL addr_v16_blank: got %0d want 0", txt_addr); end
    tick(1'b1);
    checks++;
    if ({von, row} !== {1'b0, 4'd0}) begin errors++; $display("FAIL pix_v16: von/row got %h want 0", {von, row}); end
  endtask

  task automatic test_frame();
    int hs_lo = 0, hs_l0 = 0, vs_lo = 0, vs_fall = -1, fs_cnt = 0, fs_at = -1;
    logic pv;
    do_reset();
    tick(1'b1);
    tick(1'b1);
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL frame_fs_first: got %b want 1", frame_start); end
    pv = vsync;
    for (int n = 1; n <= 16800; n++) begin
      tick(1'b1);
      if (!hsync) hs_lo++;
      if (!hsync && n < 800) hs_l0++;
      if (!vsync) vs_lo++;
      if (pv && !vsync && vs_fall < 0) vs_fall = n;
      pv = vsync;
      if (frame_start) begin fs_cnt++; fs_at = n; end
    end
    checks++;
    if (hs_l0 !== 96) begin errors++; $display("FAIL hsync_low_line0: got %0d want 96", hs_l0); end
    checks++;
    if (hs_lo !== 2016) begin errors++; $display("FAIL hsync_low_frame: got %0d want 2016", hs_lo); end
    checks++;
    if (vs_lo !== 1600) begin errors++; $display("FAIL vsync_low_frame: got %0d want 1600", vs_lo); end
    checks++;
    if (vs_fall !== 14400) begin errors++; $display("FAIL vsync_fall_pos: got %0d want 14400", vs_fall); end
    checks++;
    if ({fs_cnt, fs_at} !== {32'd1, 32'd16800}) begin errors++; $display("FAIL frame_fs_period: count %0d at %0d want 1 at 16800", fs_cnt, fs_at); end
  endtask

  task automatic test_toggle();
    int c = 0, fs_n = 0, fs1 = -1, fs2 = -1, hf1 = -1, hf2 = -1, bad = 0;
    logic [22:0] prev;
    logic prev_hs, ce;
    do_reset();
    prev = out_v;
    prev_hs = hsync;
    while (fs_n < 2 && c < 34000) begin
      ce = (c % 2 == 0);
      tick(ce);
      c++;
      if (!ce && out_v[22:1] !== prev[22:1]) bad++;
      if (!ce && frame_start) bad++;
      if (frame_start) begin fs_n++; if (fs_n == 1) fs1 = c; else fs2 = c; end
      if (prev_hs && !hsync) begin if (hf1 < 0) hf1 = c; else if (hf2 < 0) hf2 = c; end
      prev = out_v;
      prev_hs = hsync;
    end
    checks++;
    if (fs1 !== 3) begin errors++; $display("FAIL toggle_fs_first: got clk %0d want 3", fs1); end
    checks++;
    if (fs2 - fs1 !== 33600) begin errors++; $display("FAIL toggle_frame_period: got %0d want 33600", fs2 - fs1); end
    checks++;
    if (hf2 - hf1 !== 1600) begin errors++; $display("FAIL toggle_line_period: got %0d want 1600", hf2 - hf1); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL toggle_hold: got %0d bad idle cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_first();
    test_mid_reset();
    test_blank();
    test_last();
    test_frame();
    test_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
